// File: rtl/decode_stage.sv
// Decode stage: instruction decode, bypassed register file, load-use detection
// and the ID/EX pipeline register with stall and flush.

module control #(
   parameter int ALU_CTRL_W = 2
) (
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   output logic                  reg_write,
   output logic                  mem_write,
   output logic                  jump,
   output logic                  branch,
   output logic                  alu_src_a,
   output logic                  alu_src_b,
   output logic [1:0]            result_src,
   output logic [2:0]            imm_src,
   output logic [2:0]            branch_type,
   output logic [2:0]            addr_ctrl,
   output logic [ALU_CTRL_W-1:0] alu_control
);
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);

   logic [ALU_CTRL_W-1:0] aluFromFunct;

   always_comb begin
      case (funct3)
         3'b111:  aluFromFunct = ALU_AND;
         3'b110:  aluFromFunct = ALU_OR;
         default: aluFromFunct = ALU_ADD;
      endcase
   end

   // imm_src: 0 = I, 1 = S, 2 = B, 3 = J, 4 = U; result_src: 0 ALU, 1 load, 2 PC+4, 3 imm
   always_comb begin
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      result_src  = 2'b00;
      imm_src     = 3'd0;
      branch_type = 3'd0;
      addr_ctrl   = 3'd0;
      alu_control = ALU_ADD;
      case (op)
         7'b0000011: begin
            reg_write  = 1'b1;
            alu_src_b  = 1'b1;
            result_src = 2'b01;
            addr_ctrl  = funct3;
         end
         7'b0100011: begin
            mem_write = 1'b1;
            alu_src_b = 1'b1;
            imm_src   = 3'd1;
            addr_ctrl = funct3;
         end
         7'b0110011: begin
            reg_write   = 1'b1;
            alu_control = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : aluFromFunct;
         end
         7'b0010011: begin
            reg_write   = 1'b1;
            alu_src_b   = 1'b1;
            alu_control = aluFromFunct;
         end
         7'b1100011: begin
            branch      = 1'b1;
            imm_src     = 3'd2;
            branch_type = funct3;
            alu_control = ALU_SUB;
         end
         7'b1101111: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 1'b1;
            result_src = 2'b10;
            imm_src    = 3'd3;
         end
         7'b1100111: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            alu_src_b  = 1'b1;
            result_src = 2'b10;
         end
         7'b0110111: begin
            reg_write  = 1'b1;
            result_src = 2'b11;
            imm_src    = 3'd4;
         end
         7'b0010111: begin
            reg_write = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            imm_src   = 3'd4;
         end
         default: ;
      endcase
   end
endmodule

module sign_ext #(
   parameter int XLEN = 32
) (
   input  logic [31:7]     instr,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm
);
   logic [31:0] imm32;

   always_comb begin
      case (imm_src)
         3'd1:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         3'd2:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         3'd3:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         3'd4:    imm32 = {instr[31:12], 12'b0};
         default: imm32 = {{20{instr[31]}}, instr[31:20]};
      endcase
   end

   assign imm = XLEN'($signed(imm32));
endmodule

module decode_stage #(
   parameter int XLEN       = 32,
   parameter int NREGS      = 32,
   parameter int BYPASS     = 1,
   parameter int ALU_CTRL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr_d,
   input  logic [XLEN-1:0]       pc_d,
   input  logic                  valid_d,
   input  logic                  stall_e,
   input  logic                  flush_e,
   input  logic                  wb_we,
   input  logic [4:0]            wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   output logic                  stall_d,
   output logic [XLEN-1:0]       rd1_e,
   output logic [XLEN-1:0]       rd2_e,
   output logic [XLEN-1:0]       imm_e,
   output logic [XLEN-1:0]       pc_e,
   output logic [4:0]            rs1_e,
   output logic [4:0]            rs2_e,
   output logic [4:0]            rd_e,
   output logic                  valid_e,
   output logic                  reg_write_e,
   output logic                  mem_write_e,
   output logic                  jump_e,
   output logic                  branch_e,
   output logic                  alu_src_a_e,
   output logic                  alu_src_b_e,
   output logic [1:0]            result_src_e,
   output logic [2:0]            branch_type_e,
   output logic [2:0]            addr_ctrl_e,
   output logic [ALU_CTRL_W-1:0] alu_control_e,
   output logic [XLEN-1:0]       a0
);
   localparam int AW = $clog2(NREGS);

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rd1;
      logic [XLEN-1:0]       rd2;
      logic [XLEN-1:0]       imm;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic                  reg_write;
      logic                  mem_write;
      logic                  jump;
      logic                  branch;
      logic                  alu_src_a;
      logic                  alu_src_b;
      logic [1:0]            result_src;
      logic [2:0]            branch_type;
      logic [2:0]            addr_ctrl;
      logic [ALU_CTRL_W-1:0] alu_control;
   } idex_t;

   logic [XLEN-1:0] regs [NREGS];
   logic [4:0]      rs1, rs2, rd;
   logic [AW-1:0]   rs1i, rs2i, waddr;
   logic [XLEN-1:0] rd1, rd2, imm;
   logic [2:0]      immSrc;
   idex_t           dec, ex;
   logic            loadUse;

   logic                  cRegWrite, cMemWrite, cJump, cBranch, cAluSrcA, cAluSrcB;
   logic [1:0]            cResultSrc;
   logic [2:0]            cBranchType, cAddrCtrl;
   logic [ALU_CTRL_W-1:0] cAluControl;

   assign rs1   = instr_d[19:15];
   assign rs2   = instr_d[24:20];
   assign rd    = instr_d[11:7];
   assign rs1i  = rs1[AW-1:0];
   assign rs2i  = rs2[AW-1:0];
   assign waddr = wb_addr[AW-1:0];

   control #(.ALU_CTRL_W(ALU_CTRL_W)) u_control (
      .op(instr_d[6:0]), .funct3(instr_d[14:12]), .funct7b5(instr_d[30]),
      .reg_write(cRegWrite), .mem_write(cMemWrite), .jump(cJump), .branch(cBranch),
      .alu_src_a(cAluSrcA), .alu_src_b(cAluSrcB), .result_src(cResultSrc),
      .imm_src(immSrc), .branch_type(cBranchType), .addr_ctrl(cAddrCtrl),
      .alu_control(cAluControl)
   );

   sign_ext #(.XLEN(XLEN)) u_sign_ext (
      .instr(instr_d[31:7]), .imm_src(immSrc), .imm(imm)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_we && waddr != '0) begin
         regs[waddr] <= wb_data;
      end
   end

   // Write-first: a writeback landing this cycle is visible to the decode read
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1i != '0) begin
         rd1 = regs[rs1i];
         if (BYPASS != 0 && wb_we && waddr == rs1i) rd1 = wb_data;
      end
      if (rs2i != '0) begin
         rd2 = regs[rs2i];
         if (BYPASS != 0 && wb_we && waddr == rs2i) rd2 = wb_data;
      end
   end

   generate
      if (NREGS > 10) begin : g_a0
         assign a0 = regs[10];
      end else begin : g_no_a0
         assign a0 = '0;
      end
   endgenerate

   assign loadUse = ex.valid && ex.result_src == 2'b01 && ex.rd != 5'd0 && valid_d &&
                    (ex.rd == rs1 || ex.rd == rs2);
   assign stall_d = loadUse || stall_e;

   always_comb begin
      dec = '0;
      if (valid_d) begin
         dec.valid       = 1'b1;
         dec.pc          = pc_d;
         dec.rd1         = rd1;
         dec.rd2         = rd2;
         dec.imm         = imm;
         dec.rs1         = rs1;
         dec.rs2         = rs2;
         dec.rd          = rd;
         dec.reg_write   = cRegWrite;
         dec.mem_write   = cMemWrite;
         dec.jump        = cJump;
         dec.branch      = cBranch;
         dec.alu_src_a   = cAluSrcA;
         dec.alu_src_b   = cAluSrcB;
         dec.result_src  = cResultSrc;
         dec.branch_type = cBranchType;
         dec.addr_ctrl   = cAddrCtrl;
         dec.alu_control = cAluControl;
      end
   end

   // A bubble is all-zero; stall_e outranks the load-use bubble
   always_ff @(posedge clk) begin
      if (rst || flush_e) begin
         ex <= '0;
      end else if (!stall_e) begin
         ex <= loadUse ? '0 : dec;
      end
   end

   assign valid_e       = ex.valid;
   assign pc_e          = ex.pc;
   assign rd1_e         = ex.rd1;
   assign rd2_e         = ex.rd2;
   assign imm_e         = ex.imm;
   assign rs1_e         = ex.rs1;
   assign rs2_e         = ex.rs2;
   assign rd_e          = ex.rd;
   assign reg_write_e   = ex.reg_write;
   assign mem_write_e   = ex.mem_write;
   assign jump_e        = ex.jump;
   assign branch_e      = ex.branch;
   assign alu_src_a_e   = ex.alu_src_a;
   assign alu_src_b_e   = ex.alu_src_b;
   assign result_src_e  = ex.result_src;
   assign branch_type_e = ex.branch_type;
   assign addr_ctrl_e   = ex.addr_ctrl;
   assign alu_control_e = ex.alu_control;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised decode stage for the pipelined core.
- Decodes `instr_d` through the existing `control` and `sign_ext` units and reads a bypassed register file.
- Detects load-use hazards and registers everything into the ID/EX pipeline register, which supports stall and flush.
- Sits between the fetch register (F/D) and the execute stage. Writeback drives the register-file write port.

Parameters:
- XLEN, 32, datapath width of registers, immediates and PC.
- NREGS, 32, number of architectural registers (power of 2, ≤32). Register address width is clog2(NREGS).
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to decode reads; when 0 the read returns the stored value.
- ALU_CTRL_W, 2, ALU control width; must match the `control` unit.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- instr_d  in  32  instruction from F/D
- pc_d  in  XLEN  PC of instr_d
- valid_d  in  1  instr_d is a real instruction
- stall_e  in  1  hold the ID/EX register
- flush_e  in  1  load a bubble into ID/EX (branch/jump taken)
- wb_we  in  1  register-file write enable
- wb_addr  in  5  write address (upper bits beyond clog2(NREGS) ignored)
- wb_data  in  XLEN  write data
- stall_d  out  1  upstream must hold F/D and PC (combinational)
- rd1_e, rd2_e  out  XLEN  registered operand values
- imm_e  out  XLEN  registered sign-extended immediate
- pc_e  out  XLEN  registered PC
- rs1_e, rs2_e, rd_e  out  5 each  registered register indices
- valid_e  out  1  registered valid
- reg_write_e, mem_write_e, jump_e, branch_e, alu_src_a_e, alu_src_b_e  out  1 each  registered control
- result_src_e  out  2  registered control; 2'b01 = load
- branch_type_e, addr_ctrl_e  out  3 each  registered control
- alu_control_e  out  ALU_CTRL_W  registered control
- a0  out  XLEN  stored x10 value, no bypass (debug/test)

Behaviour:
- Field extraction:
  - rs1 = instr_d[19:15], rs2 = instr_d[24:20], rd = instr_d[11:7].
  - `control` receives op [6:0], funct3 [14:12] and funct7 bit [30].
  - `sign_ext` receives instr_d[31:7] and ImmSrc.
- Register file:
  - NREGS × XLEN.
  - Write is synchronous on clk when wb_we=1 and wb_addr≠0. Writes to x0 are ignored, and x0 always reads 0.
  - Writes occur regardless of stall_e, flush_e or stall_d.
  - rst clears all registers to 0 on the clock edge.
  - Reads are combinational.
  - With BYPASS=1: if wb_we=1, wb_addr==rs and rs≠0, the read returns wb_data. This is write-first within the cycle.
- Load-use hazard:
  - Condition: load_use = valid_e & (result_src_e==2'b01) & (rd_e≠0) & valid_d & (rd_e==rs1 | rd_e==rs2).
  - Both rs1 and rs2 are compared regardless of instruction format; false positives are acceptable.
  - stall_d = load_use | stall_e.
- ID/EX register update, on rising edge, first matching rule wins:
  1. rst: all E outputs become 0.
  2. flush_e: bubble (all E outputs 0).
  3. stall_e: hold all E outputs.
  4. load_use: bubble. F/D is held by stall_d, so the dependent instruction re-decodes next cycle and sees the loaded value via writeback/bypass.
  5. Otherwise: capture the decoded fields.
     - When valid_d=0, capture as a bubble.
- A bubble is exactly all-zero, so reg_write_e=mem_write_e=jump_e=branch_e=valid_e=0.
- Latency: one cycle from instr_d to E outputs.
- a0 reflects x10 one cycle after the write edge; it is 0 after reset.
- rst asserted mid-stall clears E on that edge; stall_d then drops unless stall_e is still high.

Test Plan:
- Reset: drive rst=1 for 2 cycles with arbitrary instr_d → all E outputs 0, a0=0, stall_d=stall_e.
- Decode and x0:
  - instr_d=0x00700293 (addi x5,x0,7), valid_d=1 → next cycle rd_e=5, rs1_e=0, rd1_e=0, imm_e=7, reg_write_e=1, alu_src_b_e=1, valid_e=1.
  - wb_we=1, wb_addr=0, wb_data=0xDEAD → x0 still reads 0.
- Bypass: wb_we=1, wb_addr=5, wb_data=7 in the same cycle as instr_d=0x005303B3 (add x7,x6,x5):
  - BYPASS=1 → rd2_e=7.
  - BYPASS=0 → rd2_e equals the old x5 value, here 0.
- Load-use:
  - 0x0002A303 (lw x6,0(x5)) captured in E, then instr_d=0x005303B3 → stall_d=1 that cycle.
  - Next edge E holds a bubble (valid_e=0, reg_write_e=0).
  - Following cycle stall_d=0 and the add is captured with rs1_e=6.
- Priority:
  - stall_e=1 with new instr_d → E outputs unchanged, stall_d=1.
  - flush_e=1 and stall_e=1 together → E becomes a bubble.
- a0: wb_we=1, wb_addr=10, wb_data=0x12345678 → a0=0x12345678 after the edge. Assert rst → a0=0 after the next edge.
